// File: rtl/qe_gen_pkg.sv
// Shared types for the quadrature encoder generator: i/q phase encoding,
// direction constants and the command FSM states.
package qe_pkg;

  // Phase encoding is {i,q}, so the outputs come straight off the phase flops.
  typedef enum logic [1:0] {
    PH00 = 2'b00,
    PH10 = 2'b10,
    PH11 = 2'b11,
    PH01 = 2'b01
  } qe_phase_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } qe_gen_st_t;

  localparam logic DIR_FWD = 1'b0;
  localparam logic DIR_REV = 1'b1;

  function automatic qe_phase_t ph_next(input qe_phase_t p);
    case (p)
      PH00:    ph_next = PH10;
      PH10:    ph_next = PH11;
      PH11:    ph_next = PH01;
      default: ph_next = PH00;
    endcase
  endfunction

  function automatic qe_phase_t ph_prev(input qe_phase_t p);
    case (p)
      PH00:    ph_prev = PH01;
      PH01:    ph_prev = PH11;
      PH11:    ph_prev = PH10;
      default: ph_prev = PH00;
    endcase
  endfunction

endpackage

// File: rtl/qe_gen_if.sv
// Step command channel of the quadrature encoder generator: valid/ready
// handshake carrying a signed step count and an edge period.
interface qe_gen_if #(
  parameter int W  = 4,
  parameter int DW = 8
);
  logic          step_valid;
  logic          step_ready;
  logic [W-1:0]  step_count;
  logic [DW-1:0] period;

  modport master (output step_valid, output step_count, output period, input step_ready);
  modport slave  (input step_valid, input step_count, input period, output step_ready);
endinterface

// File: rtl/qe_gen_tick.sv
// Reloadable down-counter: tick is high for the enabled cycle in which the
// count has reached zero; load takes priority over counting.
module qe_gen_tick #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [DW-1:0] val,
  input  logic          en,
  output logic          tick
);
  localparam logic [DW-1:0] CNT_ONE = DW'(1);

  logic [DW-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= val;
    end else if (en && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - CNT_ONE;
    end
  end

  assign tick = en && (cnt_reg == '0);
endmodule

// File: rtl/qe_gen.sv
// Quadrature encoder generator: turns signed step commands into x4 i/q edges
// and tracks its own position. Index output z is built only with QE_GEN_INDEX_EN.
module qe_gen
  import qe_pkg::*;
#(
  parameter int W  = 4,
  parameter int DW = 8,
  parameter int IW = 2
) (
  input  logic                clk,
  input  logic                rst,
  qe_gen_if.slave             cmd,
  input  logic                abort,
  input  logic                clr,
  output logic                i,
  output logic                q,
  output logic                busy,
  output logic signed [W-1:0] pos
`ifdef QE_GEN_INDEX_EN
  ,
  output logic                z
`endif
);
  localparam logic [W-1:0] POS_ONE = W'(1);
  localparam logic [W:0]   REM_ONE = (W + 1)'(1);

  if (IW + 2 > W) begin : g_iw_range
    $error("qe_gen: index period IW+2 must not exceed position width W");
  end

  qe_gen_st_t    state_reg, state_next;
  qe_phase_t     phase_reg, phase_next;
  logic [W:0]    rem_reg, rem_next;
  logic          dir_reg, dir_next;
  logic [DW-1:0] period_reg, period_next;
  logic [W-1:0]  pos_reg, pos_next;

  logic [W:0]    sc_ext;
  logic [W:0]    abs_count;
  logic          start;
  logic          tick_en;
  logic          tick_load;
  logic          step_edge;
  logic [DW-1:0] tick_val;

  // Magnitude taken one bit wider so the most negative count is a legal length.
  assign sc_ext    = {cmd.step_count[W-1], cmd.step_count};
  assign abs_count = sc_ext[W] ? (~sc_ext + REM_ONE) : sc_ext;

  assign cmd.step_ready = (state_reg == IDLE);
  assign start          = cmd.step_valid && (state_reg == IDLE) && (abs_count != '0);
  assign tick_en        = (state_reg == RUN) && (rem_reg != '0) && !abort;
  assign tick_load      = start || step_edge;
  assign tick_val       = start ? cmd.period : period_reg;

  qe_gen_tick #(.DW(DW)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .load (tick_load),
    .val  (tick_val),
    .en   (tick_en),
    .tick (step_edge)
  );

  always_comb begin
    state_next  = state_reg;
    phase_next  = phase_reg;
    rem_next    = rem_reg;
    dir_next    = dir_reg;
    period_next = period_reg;
    pos_next    = pos_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next  = RUN;
          rem_next    = abs_count;
          dir_next    = sc_ext[W] ? DIR_REV : DIR_FWD;
          period_next = cmd.period;
        end
      end
      default: begin
        // The cycle after the final edge is still RUN, so busy drops one clock late.
        if (abort || (rem_reg == '0)) begin
          state_next = IDLE;
          rem_next   = '0;
        end else if (step_edge) begin
          rem_next   = rem_reg - REM_ONE;
          phase_next = (dir_reg == DIR_REV) ? ph_prev(phase_reg) : ph_next(phase_reg);
          pos_next   = (dir_reg == DIR_REV) ? (pos_reg - POS_ONE) : (pos_reg + POS_ONE);
        end
      end
    endcase
    if (clr) begin
      pos_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      phase_reg  <= PH00;
      rem_reg    <= '0;
      dir_reg    <= DIR_FWD;
      period_reg <= '0;
      pos_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      phase_reg  <= phase_next;
      rem_reg    <= rem_next;
      dir_reg    <= dir_next;
      period_reg <= period_next;
      pos_reg    <= pos_next;
    end
  end

  assign i    = phase_reg[1];
  assign q    = phase_reg[0];
  assign busy = (state_reg == RUN);
  assign pos  = $signed(pos_reg);

`ifdef QE_GEN_INDEX_EN
  logic z_reg;

  // Built from the next-state values so z lines up with the i/q flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      z_reg <= 1'b0;
    end else begin
      z_reg <= (phase_next == PH00) && (pos_next[IW+1:0] == '0);
    end
  end

  assign z = z_reg;
`endif
endmodule

// File: tb/tb_qe_gen.sv
// Self-checking bench for qe_gen: per-clock reference model of edge timing,
// position and phase, plus an independent x4 decoder watching i/q.
module tb_qe_gen;
  localparam int W  = 4;
  localparam int DW = 8;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst, abort, clr, i, q, busy;
  logic signed [W-1:0] pos;
`ifdef QE_GEN_INDEX_EN
  logic z;
`endif

  qe_gen_if #(.W(W), .DW(DW)) cmd ();

  qe_gen #(.W(W), .DW(DW), .IW(IW)) dut (
    .clk   (clk),
    .rst   (rst),
    .cmd   (cmd),
    .abort (abort),
    .clr   (clr),
    .i     (i),
    .q     (q),
    .busy  (busy),
    .pos   (pos)
`ifdef QE_GEN_INDEX_EN
    ,
    .z     (z)
`endif
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: forward order of (i,q) states and running totals.
  logic [1:0] seq [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
  int m_idx = 0;
  int m_pos = 0;

  // Independent decoder
  int dec_count = 0;
  int dec_off   = 0;
  logic [1:0] dec_prev = 2'b00;

  function automatic int ph_of(input logic [1:0] v);
    for (int k = 0; k < 4; k++) begin
      if (seq[k] == v) return k;
    end
    return 0;
  endfunction

  always @(posedge clk) begin
    logic [1:0] cur;
    int d;
    #1;
    if (rst) begin
      dec_prev  = 2'b00;
      dec_count = 0;
    end else begin
      cur = {i, q};
      if (cur != dec_prev) begin
        d = (ph_of(cur) - ph_of(dec_prev) + 4) % 4;
        n_total++;
        if (d == 2) $display("FAIL decoder_step: (i,q) %b -> %b, required one-bit change", dec_prev, cur);
        else n_pass++;
        if (d == 1) dec_count++;
        else if (d == 3) dec_count--;
        dec_prev = cur;
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1; abort = 1'b0; clr = 1'b0;
    cmd.step_valid = 1'b0; cmd.step_count = '0; cmd.period = '0;
    repeat (2) @(posedge clk);
    #2;
    n_total++;
    if ({i, q, busy, cmd.step_ready} !== 4'b0001) $display("FAIL reset_ctrl: i,q,busy,ready=%b required 0001", {i, q, busy, cmd.step_ready});
    else n_pass++;
    n_total++;
    if (pos !== 4'sd0) $display("FAIL reset_pos: pos=%0d required 0", pos);
    else n_pass++;
`ifdef QE_GEN_INDEX_EN
    n_total++;
    if (z !== 1'b0) $display("FAIL reset_z: z=%b required 0", z);
    else n_pass++;
`endif
    @(negedge clk);
    rst = 1'b0;
    m_idx = 0; m_pos = 0; dec_off = 0;
  endtask

  task automatic do_clr();
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #2;
    m_pos = 0;
    dec_off = dec_count;
    n_total++;
    if (pos !== 4'sd0) $display("FAIL clr_idle: pos=%0d required 0", pos);
    else n_pass++;
    @(negedge clk);
    clr = 1'b0;
  endtask

  // Issue one command and check every clock until it has settled.
  task automatic run_cmd(input int sc, input int per, input int abort_at, input int clr_at, input bit aoa);
    int n, dir, k, span, limit, t, dd;
    bit aborted, exp_busy;
    logic [1:0] exp_iq;
    logic [3:0] exp_pos, dv;
    n = (sc < 0) ? -sc : sc;
    dir = (sc < 0) ? -1 : 1;
    span = n * (per + 1);
    limit = (abort_at > 0) ? abort_at + 1 : span + 2;
    k = 0; aborted = 1'b0;
    @(negedge clk);
    cmd.step_valid = 1'b1; cmd.step_count = sc[3:0]; cmd.period = per[7:0];
    abort = aoa; clr = 1'b0;
    n_total++;
    if (cmd.step_ready !== 1'b1) $display("FAIL ready_before_accept: ready=%b required 1", cmd.step_ready);
    else n_pass++;
    @(posedge clk);
    #2;
    n_total++;
    if (busy !== (n != 0)) $display("FAIL busy_at_accept: busy=%b required %b", busy, (n != 0));
    else n_pass++;
    for (int c = 1; c <= limit; c++) begin
      @(negedge clk);
      cmd.step_valid = 1'b0;
      abort = (c == abort_at);
      clr = (c == clr_at);
      @(posedge clk);
      if (!aborted) begin
        if (c == abort_at) aborted = 1'b1;
        else if ((k < n) && (c % (per + 1) == 0)) begin
          k++; m_idx += dir; m_pos += dir;
        end
      end
      if (c == clr_at) m_pos = 0;
      #2;
      if (c == clr_at) dec_off = dec_count;
      exp_busy = !aborted && (c <= span);
      exp_iq = seq[((m_idx % 4) + 4) % 4];
      t = m_pos; exp_pos = t[3:0];
      dd = dec_count - dec_off; dv = dd[3:0];
      n_total++;
      if ({i, q} !== exp_iq) $display("FAIL iq clk%0d: (i,q)=%b required %b", c, {i, q}, exp_iq);
      else n_pass++;
      n_total++;
      if (pos !== exp_pos) $display("FAIL pos clk%0d: pos=%0d required %0d", c, pos, $signed(exp_pos));
      else n_pass++;
      n_total++;
      if ({busy, cmd.step_ready} !== {exp_busy, !exp_busy}) $display("FAIL busy_ready clk%0d: busy,ready=%b required %b", c, {busy, cmd.step_ready}, {exp_busy, !exp_busy});
      else n_pass++;
      n_total++;
      if (dv !== pos) $display("FAIL decoder_vs_pos clk%0d: pos=%0d required decoder count %0d", c, pos, $signed(dv));
      else n_pass++;
`ifdef QE_GEN_INDEX_EN
      n_total++;
      if (z !== ((exp_iq == 2'b00) && (exp_pos[IW+1:0] == '0))) $display("FAIL z clk%0d: z=%b required %b", c, z, ((exp_iq == 2'b00) && (exp_pos[IW+1:0] == '0)));
      else n_pass++;
`endif
    end
    @(negedge clk);
    abort = 1'b0; clr = 1'b0;
    $display("cmd count=%0d period=%0d abort_at=%0d clr_at=%0d aoa=%0d edges=%0d pos=%0d iq=%b",
             sc, per, abort_at, clr_at, aoa, k, pos, {i, q});
  endtask

  task automatic test_forward();
    run_cmd(3, 1, 0, 0, 1'b0);
  endtask

  task automatic test_wrap();
    run_cmd(3, 0, 0, 0, 1'b0);
    run_cmd(-7, 1, 0, 0, 1'b0);
    run_cmd(7, 0, 0, 0, 1'b0);
    run_cmd(2, 2, 0, 0, 1'b0);
  endtask

  task automatic test_extremes();
    do_clr();
    run_cmd(-8, 0, 0, 0, 1'b0);
  endtask

  task automatic test_abort();
    do_clr();
    run_cmd(5, 3, 9, 0, 1'b0);
    run_cmd(3, 1, 4, 0, 1'b0);
  endtask

  task automatic test_idle_cases();
    run_cmd(0, 2, 0, 0, 1'b0);
    run_cmd(2, 0, 0, 0, 1'b1);
  endtask

  task automatic test_clr_edge();
    run_cmd(4, 1, 0, 4, 1'b0);
    run_cmd(-6, 0, 0, 3, 1'b0);
  endtask

  task automatic test_random();
    int sc, per, n, span, ab, cl;
    for (int r = 0; r < 24; r++) begin
      sc = int'($urandom_range(15)) - 8;
      per = int'($urandom_range(3));
      n = (sc < 0) ? -sc : sc;
      span = n * (per + 1);
      ab = ((n > 0) && ($urandom_range(3) == 0)) ? int'($urandom_range(span, 1)) : 0;
      cl = ($urandom_range(4) == 0) ? int'($urandom_range(span + 1, 1)) : 0;
      run_cmd(sc, per, ab, cl, 1'($urandom_range(1)));
    end
  endtask

  task automatic test_rst_midrun();
    @(negedge clk);
    cmd.step_valid = 1'b1; cmd.step_count = 4'sd5; cmd.period = 8'd0;
    @(negedge clk);
    cmd.step_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #2;
    n_total++;
    if ({i, q, busy, cmd.step_ready} !== 4'b0001) $display("FAIL rst_midrun_ctrl: i,q,busy,ready=%b required 0001", {i, q, busy, cmd.step_ready});
    else n_pass++;
    n_total++;
    if (pos !== 4'sd0) $display("FAIL rst_midrun_pos: pos=%0d required 0", pos);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    m_idx = 0; m_pos = 0; dec_off = 0;
    run_cmd(1, 0, 0, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_forward();
    test_wrap();
    test_extremes();
    test_abort();
    test_idle_cases();
    test_clr_edge();
    test_random();
    test_rst_midrun();
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
